// File: rtl/rf_pkg.sv
// rf_pkg: shared constants, types and helpers for the scoreboarded
// register file.
//   RF_DATA_W / RF_ADDR_W : default register width / address width
//   RF_POP_MAX            : widest vector popcount() accepts (DEPTH <= 256)
//   rf_addr_t             : register address at the default width
//   popcount()            : number of set bits in a zero-extended vector
package rf_pkg;

  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_POP_MAX = 256;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  function automatic int unsigned popcount(input logic [RF_POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < RF_POP_MAX; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/regfile_sb_tracker.sv
// sb_tracker: busy-bit scoreboard for long-latency destinations.
//   clk, rst_n   : clock, synchronous active-low reset
//   iss_en/addr  : long-latency op issued, mark destination busy
//   clr_en/addr  : long-latency writeback, release destination
//   flush        : drop every busy bit (wins over issue)
//   busy         : current busy vector, one bit per register
//   busy_cnt     : registered popcount of the busy vector
// Priority per bit: flush > issue > clear > hold.
module sb_tracker
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [DEPTH-1:0]      iss_vec, clr_vec;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RF_POP_MAX-1:0] pop_in;
  logic                  iss_ok;

  // The hard-wired zero register can never own a pending result.
  assign iss_ok  = iss_en & ~(ZERO_REG && (iss_addr == '0));
  assign iss_vec = iss_ok ? (DEPTH'(1) << iss_addr) : '0;
  assign clr_vec = clr_en ? (DEPTH'(1) << clr_addr) : '0;

  // Issue ORed in after the clear so a same-cycle issue/writeback pair
  // leaves the register owned by the newer op.
  always_comb begin
    busy_d = flush ? '0 : ((busy_q & ~clr_vec) | iss_vec);
  end

  always_comb begin
    pop_in             = '0;
    pop_in[DEPTH-1:0]  = busy_d;
    cnt_d              = CNT_W'(popcount(pop_in));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register bank with NUM_RD combinational read ports, an ALU
// writeback port (wr0), a long-latency writeback port (wr1) and an
// integrated RAW scoreboard.
//   clk, rst_n          : clock, synchronous active-low reset
//   rd_addr / rd_data   : packed read ports, port k at [k*W +: W]
//   rd_busy             : per read port, destination still pending
//   wr0_en/addr/data    : single-cycle writeback
//   wr1_en/addr/data    : long-latency writeback, releases busy bit
//   iss_en/iss_addr     : long-latency issue, marks destination busy
//   flush               : clear all busy bits, data untouched
//   wr_collide          : both write ports hit one register last cycle
//   busy_cnt            : number of busy registers
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic                     wr_collide,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              w0_ok, w1_ok;
  logic              collide_q, collide_d;

  // Writes to the zero register are dropped before they reach the array,
  // the bypass path or the collision detector.
  assign w0_ok     = wr0_en & ~(ZERO_REG && (wr0_addr == '0));
  assign w1_ok     = wr1_en & ~(ZERO_REG && (wr1_addr == '0));
  assign collide_d = w0_ok & w1_ok & (wr0_addr == wr1_addr);

  // wr0 is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      collide_q <= 1'b0;
    end else begin
      if (w1_ok) mem_q[wr1_addr] <= wr1_data;
      if (w0_ok) mem_q[wr0_addr] <= wr0_data;
      collide_q <= collide_d;
    end
  end

  assign wr_collide = collide_q;

  // wr1 always releases its destination, even when wr0 wins the data.
  sb_tracker #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .clr_en  (wr1_en),
    .clr_addr(wr1_addr),
    .flush   (flush),
    .busy    (busy),
    .busy_cnt(busy_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              w0_hit, w1_hit;

    assign ra     = rd_addr[k*ADDR_W +: ADDR_W];
    assign w0_hit = BYPASS && w0_ok && (wr0_addr == ra);
    assign w1_hit = BYPASS && w1_ok && (wr1_addr == ra);

    assign rd_data[k*DATA_W +: DATA_W] =
      (ZERO_REG && (ra == '0)) ? '0       :
      w0_hit                   ? wr0_data :
      w1_hit                   ? wr1_data :
                                 mem_q[ra];

    // A forwarded long-latency result releases the stall in its own cycle.
    assign rd_busy[k] = busy[ra] & ~(BYPASS && wr1_en && (wr1_addr == ra));
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        wr0_en, wr1_en, iss_en, flush;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic        wr_collide, wr_collide_nb;
  logic [5:0]  busy_cnt, busy_cnt_nb;

  logic [31:0] exp_q [$];
  logic [31:0] exp;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .wr_collide(wr_collide), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .wr0_en(wr0_en), .wr0_addr(wr0_addr),
    .wr0_data(wr0_data), .wr1_en(wr1_en), .wr1_addr(wr1_addr),
    .wr1_data(wr1_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .wr_collide(wr_collide_nb), .busy_cnt(busy_cnt_nb)
  );

  task automatic idle();
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    iss_en = 0; iss_addr = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL reset_init_cnt got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL reset_init_col got %h exp %h", wr_collide, exp); end
    tick();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    tick();
    idle(); rd_addr = {5'd6, 5'd5};
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL reset_pre_r5 got %h exp %h", rd_data[31:0], exp); end
    // inputs during reset must be ignored
    rst_n = 0; wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234; iss_en = 1; iss_addr = 6;
    tick(); tick();
    rst_n = 1; idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL reset_r5 got %h exp %h", rd_data[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL reset_cnt got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL reset_col got %h exp %h", wr_collide, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL reset_busy_r6 got %h exp %h", rd_busy, exp); end
    tick();
  endtask

  task automatic test_collision();
    iss_en = 1; iss_addr = 7;
    tick();
    idle();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11111111;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22222222;
    rd_addr = {5'd7, 5'd7};
    exp_q.push_back(32'h11111111); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL col_bypass got %h exp %h", rd_data[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[0]} !== exp) begin errors++; $display("FAIL col_rdbusy got %h exp %h", rd_busy[0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL col_cnt_pre got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data_nb[31:0] !== exp) begin errors++; $display("FAIL col_nb_old got %h exp %h", rd_data_nb[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy_nb[0]} !== exp) begin errors++; $display("FAIL col_nb_busy got %h exp %h", rd_busy_nb[0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL col_pre got %h exp %h", wr_collide, exp); end
    tick();
    idle();
    exp_q.push_back(32'h11111111); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_nb[31:0] !== exp) begin errors++; $display("FAIL col_r7 got %h exp %h", rd_data_nb[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL col_pulse got %h exp %h", wr_collide, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL col_cnt got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, rd_busy[0]} !== exp) begin errors++; $display("FAIL col_busy7 got %h exp %h", rd_busy[0], exp); end
    tick();
    exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL col_one_cycle got %h exp %h", wr_collide, exp); end
    tick();
  endtask

  task automatic test_zero_reg();
    iss_en = 1; iss_addr = 2;
    tick();
    idle();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 0;
    rd_addr = {5'd0, 5'd0};
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL zero_bypass got %h exp %h", rd_data[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL zero_busy_pre got %h exp %h", rd_busy, exp); end
    tick();
    idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_nb[31:0] !== exp) begin errors++; $display("FAIL zero_r0 got %h exp %h", rd_data_nb[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL zero_busy got %h exp %h", rd_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL zero_cnt got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL zero_col got %h exp %h", wr_collide, exp); end
    wr1_en = 1; wr1_addr = 2; wr1_data = 32'h2;
    tick();
    idle();
    exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL zero_cnt_clr got %h exp %h", busy_cnt, exp); end
    tick();
  endtask

  task automatic test_bypass();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hAABBCCDD;
    iss_en = 1; iss_addr = 3;
    tick();
    idle();
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'hCAFEF00D;
    rd_addr = {5'd3, 5'd3};
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'd0);
    exp_q.push_back(32'hAABBCCDD); exp_q.push_back(32'd3);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data[63:32] !== exp) begin errors++; $display("FAIL byp_data got %h exp %h", rd_data[63:32], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL byp_busy got %h exp %h", rd_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data_nb[63:32] !== exp) begin errors++; $display("FAIL nobyp_data got %h exp %h", rd_data_nb[63:32], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy_nb} !== exp) begin errors++; $display("FAIL nobyp_busy got %h exp %h", rd_busy_nb, exp); end
    tick();
    idle();
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'd0);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (rd_data_nb[31:0] !== exp) begin errors++; $display("FAIL byp_after got %h exp %h", rd_data_nb[31:0], exp); end
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt_nb} !== exp) begin errors++; $display("FAIL byp_cnt got %h exp %h", busy_cnt_nb, exp); end
    tick();
  endtask

  task automatic test_priority();
    iss_en = 1; iss_addr = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h99;
    tick();
    idle();
    flush = 1; iss_en = 1; iss_addr = 10;
    rd_addr = {5'd10, 5'd9};
    exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL prio_cnt got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL prio_busy9 got %h exp %h", rd_busy, exp); end
    tick();
    idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h99);
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL flush_cnt got %h exp %h", busy_cnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL flush_busy got %h exp %h", rd_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp) begin errors++; $display("FAIL prio_r9 got %h exp %h", rd_data[31:0], exp); end
    tick();
  endtask

  task automatic test_saturation();
    rd_addr = {5'd31, 5'd1};
    for (int i = 1; i < 32; i++) begin
      idle(); iss_en = 1; iss_addr = 5'(i);
      exp_q.push_back(32'(i));
      tick();
      iss_en = 0;
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL sat_up got %h exp %h", busy_cnt, exp); end
    end
    exp_q.push_back(32'd3);
    exp = exp_q.pop_front(); checks++;
    if ({30'd0, rd_busy} !== exp) begin errors++; $display("FAIL sat_busy got %h exp %h", rd_busy, exp); end
    for (int j = 31; j > 0; j--) begin
      idle(); wr1_en = 1; wr1_addr = 5'(j); wr1_data = 32'(j);
      exp_q.push_back(32'(j - 1));
      tick();
      wr1_en = 0;
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if ({26'd0, busy_cnt} !== exp) begin errors++; $display("FAIL sat_down got %h exp %h", busy_cnt, exp); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] m [32];
    logic [4:0]  ra [2];
    logic        col_prev;
    m[0] = 0;
    for (int i = 1; i < 32; i++) m[i] = 32'(i);
    col_prev = 0;
    for (int n = 0; n < 150; n++) begin
      idle();
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = 5'($urandom_range(0, 31)); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_data = $urandom;
      wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
      ra[0] = ($urandom_range(0, 2) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
      ra[1] = ($urandom_range(0, 2) == 0) ? wr1_addr : 5'($urandom_range(0, 31));
      rd_addr = {ra[1], ra[0]};
      for (int k = 0; k < 2; k++) begin
        if (ra[k] == 0)                         exp_q.push_back(32'd0);
        else if (wr0_en && wr0_addr == ra[k])   exp_q.push_back(wr0_data);
        else if (wr1_en && wr1_addr == ra[k])   exp_q.push_back(wr1_data);
        else                                    exp_q.push_back(m[ra[k]]);
      end
      exp_q.push_back(m[ra[0]]); exp_q.push_back(m[ra[1]]);
      exp_q.push_back({31'd0, col_prev});
      @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (rd_data[31:0] !== exp) begin errors++; $display("FAIL b2b_p0 got %h exp %h", rd_data[31:0], exp); end
      exp = exp_q.pop_front(); checks++;
      if (rd_data[63:32] !== exp) begin errors++; $display("FAIL b2b_p1 got %h exp %h", rd_data[63:32], exp); end
      exp = exp_q.pop_front(); checks++;
      if (rd_data_nb[31:0] !== exp) begin errors++; $display("FAIL b2b_nb_p0 got %h exp %h", rd_data_nb[31:0], exp); end
      exp = exp_q.pop_front(); checks++;
      if (rd_data_nb[63:32] !== exp) begin errors++; $display("FAIL b2b_nb_p1 got %h exp %h", rd_data_nb[63:32], exp); end
      exp = exp_q.pop_front(); checks++;
      if ({31'd0, wr_collide} !== exp) begin errors++; $display("FAIL b2b_col got %h exp %h", wr_collide, exp); end
      if (wr1_en && wr1_addr != 0) m[wr1_addr] = wr1_data;
      if (wr0_en && wr0_addr != 0) m[wr0_addr] = wr0_data;
      col_prev = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != 0);
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 0; rd_addr = 0; idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_collision();
    test_zero_reg();
    test_bypass();
    test_priority();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
